seq_multiplier: RTL
===================

// Module: seq_multiplier
//
// PURPOSE
//   Multi-cycle unsigned shift-add multiplier for the 16-bit datapath.
//   Sits upstream of the write-back 2x16 mux: product_lo (or product_hi)
//   drives the mux's in1 input, and the ALU result drives in0.
//   Control holds the mux select until done pulses.
//   Computes one partial product per clock, so no combinational array
//   multiplier is needed on the critical path.
//
// PARAMETERS
//   DATA_WIDTH  16  operand width; product is 2*DATA_WIDTH bits
//   CNT_WIDTH    5  iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH
//
// PORTS
//   clk         input   1           rising-edge clock, the single clock domain
//   rst         input   1           asynchronous, active-high reset
//   start       input   1           request; sampled on rising edge of clk
//   a           input   DATA_WIDTH  multiplicand, captured on accepted start
//   b           input   DATA_WIDTH  multiplier, captured on accepted start
//   busy        output  1           high while iterating (state RUN)
//   done        output  1           one-cycle pulse: a new product is valid
//   product_lo  output  DATA_WIDTH  low half of the registered result
//   product_hi  output  DATA_WIDTH  high half of the registered result
//
// BEHAVIOUR
//   Reset:
//     - rst=1 asynchronously forces state IDLE.
//     - Clears count, the operand registers, the accumulator, busy, done,
//       product_lo and product_hi to 0. Applies mid-operation too.
//   States:
//     - IDLE: start=1 captures a into mcand and b into mplier, clears
//       acc_hi (DATA_WIDTH+1 bits, including the carry), sets count=0,
//       and moves to RUN. With start=0 the state stays IDLE.
//     - RUN, every edge:
//       - sum = acc_hi + (mplier[0] ? mcand : 0), zero-extended.
//       - {acc_hi, mplier} <= {1'b0, sum, mplier} >> 1, a logical right
//         shift across 2*DATA_WIDTH+1 bits.
//       - count increments by 1.
//       - On the edge where count==DATA_WIDTH-1: product_hi and
//         product_lo load the final shifted value, and the state moves
//         to DONE.
//     - DONE: lasts exactly one cycle, and done=1 during it.
//       - start=1 is accepted as in IDLE and moves directly to RUN.
//       - Otherwise the next state is IDLE.
//   Outputs:
//     - busy = (state==RUN). done = (state==DONE). Both are registered
//       state decodes, so they are glitch-free.
//   Latency:
//     - start is sampled at edge E0. RUN covers edges E1..E16
//       (DATA_WIDTH edges).
//     - done and the valid product are visible in the cycle after edge
//       E0+DATA_WIDTH.
//     - Issue interval is DATA_WIDTH+1 cycles when start is held high.
//   Hold: product_lo/hi change only on the RUN->DONE edge. They hold the
//     last result through IDLE and through the following RUN.
//   Ignored input: start while busy=1 is ignored, with no restart and no
//     queueing. a and b are don't-care except at an accepted start.
//   Width rule: arithmetic is unsigned. The full 2*DATA_WIDTH product is
//     exact, with no overflow and no truncation. The carry out of each add
//     is kept in acc_hi[DATA_WIDTH].
//   Reset during RUN: done is never asserted and the outputs read 0.
//     After rst falls, the next start begins a fresh operation.
//
// TESTING
//   1. Basic: a=3, b=5, start one cycle.
//      -> busy for 16 cycles, then done for 1 cycle,
//         product_hi=0x0000, product_lo=0x000F.
//   2. Max operands: a=0xFFFF, b=0xFFFF.
//      -> product_hi=0xFFFE, product_lo=0x0001 (carry path).
//   3. Busy-start: while busy, drive start with a=7, b=7.
//      -> the original product is unchanged, with exactly one done pulse.
//   4. Held start, 1st run a=2, b=0x8000:
//      -> hi=0x0001, lo=0x0000.
//      Then a=0x1234, b=0 while in DONE:
//      -> next done 17 cycles later, with hi=lo=0.
//      Between the two results, the first product holds.
//   5. Reset mid-run: assert rst at RUN cycle 8.
//      -> busy=done=0 and product=0 immediately. A new start a=10, b=10
//         gives lo=0x0064.
//   6. Random: 1000 random a and b.
//      -> {product_hi, product_lo} == a*b; done spacing >= 17 cycles.

Source files
------------

// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-add multiplier. It produces one partial product per clock.
// Latency: start sampled at E0, done and product valid after edge E0+DATA_WIDTH; issue interval DATA_WIDTH+1.
// Backpressure: none. start is ignored while busy, and requests are never queued.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; clears state, operands, accumulator and outputs
//   start      request, accepted in IDLE or DONE
//   a, b       multiplicand / multiplier, captured on an accepted start
//   busy       high while iterating (RUN)
//   done       one-cycle pulse when a new product is valid
//   product_lo low half of the registered product
//   product_hi high half of the registered product
module seq_multiplier #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] product_lo,
    output logic [DATA_WIDTH-1:0] product_hi
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_WIDTH-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0]     mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0]     mplier_q, mplier_d;
    // One bit wider than the operands so the carry of each add is kept.
    logic [DATA_WIDTH:0]       acc_hi_q, acc_hi_d;
    logic [2*DATA_WIDTH-1:0]   prod_q, prod_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic [DATA_WIDTH:0]       addend;
    logic [DATA_WIDTH:0]       sum;
    logic                      last_iter;

    // The partial product is added only when the current multiplier LSB is set.
    // acc_hi_q[DATA_WIDTH] is always 0 on entry to an add because the previous
    // shift cleared it. The sum therefore always fits in DATA_WIDTH+1 bits.
    assign addend    = mplier_q[0] ? {1'b0, mcand_q} : '0;
    assign sum       = acc_hi_q + addend;
    assign last_iter = (count_q == CNT_WIDTH'(DATA_WIDTH - 1));

    // Next-state and datapath.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_hi_d = acc_hi_q;
        prod_d   = prod_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mcand_d  = a;
                    mplier_d = b;
                    acc_hi_d = '0;
                    count_d  = '0;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end

            RUN: begin
                // {acc_hi, mplier} <= {1'b0, sum, mplier} >> 1, written out
                // field by field. The bit shifted out of sum enters the
                // multiplier MSB, and the consumed multiplier LSB is dropped.
                acc_hi_d = {1'b0, sum[DATA_WIDTH:1]};
                mplier_d = {sum[0], mplier_q[DATA_WIDTH-1:1]};
                count_d  = count_q + CNT_WIDTH'(1);
                if (last_iter) begin
                    // After the final shift the top accumulator bit is zero.
                    // The exact 2*DATA_WIDTH product is therefore the remaining bits.
                    prod_d  = {sum, mplier_q[DATA_WIDTH-1:1]};
                    state_d = DONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // busy/done are registered from the next-state value.
    // They track the state register exactly and are free of decode glitches.
    always_comb begin
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_hi_q <= '0;
            prod_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_hi_q <= acc_hi_d;
            prod_q   <= prod_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign product_lo = prod_q[DATA_WIDTH-1:0];
    assign product_hi = prod_q[2*DATA_WIDTH-1:DATA_WIDTH];

endmodule
